// File: rtl/apb_i2c_req_arbiter_pkg.sv
// Shared types and constants for the two-requester APB sequencer that fronts
// the I2C controller register window.
package apb_i2c_req_arbiter_pkg;

  // Controller register window and register offsets inside it
  localparam logic [31:0] I2C_BASE     = 32'h8000_0000;
  localparam logic [31:0] I2C_MASK     = 32'hFFFF_FFF0;
  localparam logic [3:0]  REG_CTRL     = 4'h0;
  localparam logic [3:0]  REG_STATUS   = 4'h4;
  localparam logic [3:0]  REG_DATA     = 4'h8;
  localparam logic [3:0]  REG_CMD      = 4'hC;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  // A command may reach the bus only if it is word aligned and inside the window
  function automatic logic addr_legal(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] mask);
    return ((addr & mask) == base) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/apb_i2c_req_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: one-hot grant, remembers the last winner so a
// contended request alternates strictly.
module apb_i2c_req_arbiter_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last_grant;

  // NOTE: combinational outputs get a default before any branch so no latch is inferred.
  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
  end

  // Reset to 1 so requester 0 wins the first contended round
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (accept && (grant != 2'b00)) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/apb_i2c_req_arbiter.sv
// APB master sequencer for the I2C controller: arbitrates two single-command
// requesters, filters illegal addresses and runs fixed-length SETUP/ACCESS.
module apb_i2c_req_arbiter
  import apb_i2c_req_arbiter_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE     = I2C_BASE,
  parameter logic [31:0] ADDR_MASK     = I2C_MASK,
  parameter int unsigned ACCESS_CYCLES = 1
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        r0_req,
  input  logic        r0_write,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  output logic        r0_ack,
  output logic        r0_err,
  output logic [31:0] r0_rdata,
  input  logic        r1_req,
  input  logic        r1_write,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  output logic        r1_ack,
  output logic        r1_err,
  output logic [31:0] r1_rdata,
  output logic [31:0] PADDR,
  output logic        PSELx,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  output logic        busy,
  output logic        grant_id
);

  localparam logic [3:0] ACC_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t     state;
  logic [3:0] acc_cnt;
  logic [1:0] grant;
  cmd_t       cmd0;
  cmd_t       cmd1;
  cmd_t       cmd_sel;

  assign cmd0    = {r0_write, r0_addr, r0_wdata};
  assign cmd1    = {r1_write, r1_addr, r1_wdata};
  assign cmd_sel = grant[1] ? cmd1 : cmd0;

  apb_i2c_req_arbiter_rr_arb2 u_arb (
    .clk    (PCLK),
    .rst_n  (PRESETn),
    .req    ({r1_req, r0_req}),
    .accept (state == ST_IDLE),
    .grant  (grant)
  );

  // Every output is set on the edge that enters the state it belongs to, so
  // the bus sees only flop outputs.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state    <= ST_IDLE;
      acc_cnt  <= 4'd0;
      PADDR    <= 32'd0;
      PWDATA   <= 32'd0;
      PWRITE   <= 1'b0;
      PSELx    <= 1'b0;
      PENABLE  <= 1'b0;
      busy     <= 1'b0;
      grant_id <= 1'b0;
      r0_ack   <= 1'b0;
      r0_err   <= 1'b0;
      r0_rdata <= 32'd0;
      r1_ack   <= 1'b0;
      r1_err   <= 1'b0;
      r1_rdata <= 32'd0;
    end else begin
      r0_ack <= 1'b0;
      r1_ack <= 1'b0;
      r0_err <= 1'b0;
      r1_err <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (grant != 2'b00) begin
            grant_id <= grant[1];
            busy     <= 1'b1;
            if (addr_legal(cmd_sel.addr, ADDR_BASE, ADDR_MASK)) begin
              PADDR  <= cmd_sel.addr;
              PWDATA <= cmd_sel.wdata;
              PWRITE <= cmd_sel.write;
              PSELx  <= 1'b1;
              state  <= ST_SETUP;
            end else begin
              // Rejected commands complete at once and never touch the bus
              if (grant[1]) begin
                r1_ack <= 1'b1;
                r1_err <= 1'b1;
              end else begin
                r0_ack <= 1'b1;
                r0_err <= 1'b1;
              end
              state <= ST_DONE;
            end
          end
        end
        ST_SETUP: begin
          PENABLE <= 1'b1;
          acc_cnt <= ACC_LOAD;
          state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (acc_cnt == 4'd0) begin
            PSELx   <= 1'b0;
            PENABLE <= 1'b0;
            if (grant_id) begin
              r1_ack <= 1'b1;
              if (!PWRITE) r1_rdata <= PRDATA;
            end else begin
              r0_ack <= 1'b1;
              if (!PWRITE) r0_rdata <= PRDATA;
            end
            state <= ST_DONE;
          end else begin
            acc_cnt <= acc_cnt - 4'd1;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_i2c_req_arbiter.sv
// Directed and randomized checks of the APB I2C request arbiter against a
// transaction-level model of its arbitration, latency and data rules.
module tb_apb_i2c_req_arbiter;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] MASK = 32'hFFFF_FFF0;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        r0_req = 1'b0, r0_write = 1'b0, r1_req = 1'b0, r1_write = 1'b0;
  logic [31:0] r0_addr = '0, r0_wdata = '0, r1_addr = '0, r1_wdata = '0;
  logic        r0_ack, r0_err, r1_ack, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic [31:0] PADDR, PWDATA;
  logic [31:0] PRDATA = '0;
  logic        PSELx, PENABLE, PWRITE, busy, grant_id;

  // Second instance with a longer ACCESS phase
  logic        b_req = 1'b0, b_write = 1'b0;
  logic [31:0] b_addr = '0, b_wdata = '0;
  logic        b_r0_ack, b_r0_err, b_r1_ack, b_r1_err;
  logic [31:0] b_r0_rdata, b_r1_rdata, b_paddr, b_pwdata;
  logic        b_psel, b_penable, b_pwrite, b_busy, b_grant_id;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 PCLK = ~PCLK;

  apb_i2c_req_arbiter dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .r0_req(r0_req), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_err(r0_err), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_err(r1_err), .r1_rdata(r1_rdata),
    .PADDR(PADDR), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .busy(busy), .grant_id(grant_id)
  );

  apb_i2c_req_arbiter #(.ACCESS_CYCLES(3)) dut3 (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .r0_req(b_req), .r0_write(b_write), .r0_addr(b_addr), .r0_wdata(b_wdata),
    .r0_ack(b_r0_ack), .r0_err(b_r0_err), .r0_rdata(b_r0_rdata),
    .r1_req(1'b0), .r1_write(1'b0), .r1_addr(32'd0), .r1_wdata(32'd0),
    .r1_ack(b_r1_ack), .r1_err(b_r1_err), .r1_rdata(b_r1_rdata),
    .PADDR(b_paddr), .PSELx(b_psel), .PENABLE(b_penable), .PWRITE(b_pwrite),
    .PWDATA(b_pwdata), .PRDATA(32'h0BAD_0BAD), .busy(b_busy), .grant_id(b_grant_id)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Transaction-level model state
  logic        cw[2];
  logic [31:0] ca[2], cd[2];
  bit          pend[2];
  logic [31:0] m_rdata[2];
  logic [31:0] m_paddr, m_pwdata;
  int          m_last;

  function automatic bit legal(input logic [31:0] a);
    return ((a & MASK) == BASE) && (a % 4 == 0);
  endfunction

  task automatic drive(input int i);
    if (i == 0) begin
      r0_req = 1'b1; r0_write = cw[0]; r0_addr = ca[0]; r0_wdata = cd[0];
    end else begin
      r1_req = 1'b1; r1_write = cw[1]; r1_addr = ca[1]; r1_wdata = cd[1];
    end
  endtask

  task automatic new_cmd(input int i);
    int kind;
    kind  = $urandom_range(0, 3);
    cw[i] = 1'($urandom_range(0, 1));
    cd[i] = $urandom;
    case (kind)
      0, 1:    ca[i] = BASE + 4 * $urandom_range(0, 3);
      2:       ca[i] = $urandom;
      default: ca[i] = BASE + $urandom_range(0, 15);
    endcase
    pend[i] = 1'b1;
    drive(i);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_ack, k, win, exp_lat, sel_cnt, en_cnt;
    bit got, lg;
    logic [31:0] prd;

    // Reset values
    #12;
    check("rst_ctrl", {PSELx, PENABLE, PWRITE, busy, grant_id, r0_ack, r1_ack, r0_err, r1_err}, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_pwdata", PWDATA, 0);
    check("rst_rdata", r0_rdata | r1_rdata, 0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    tick();

    // 1: r0 write
    r0_req = 1; r0_write = 1; r0_addr = 32'h8000_0000; r0_wdata = 32'h0002_A551;
    tick();
    check("t1_c1_sel", {PSELx, PENABLE}, 2'b10);
    check("t1_c1_paddr", PADDR, 32'h8000_0000);
    check("t1_c1_pwdata", PWDATA, 32'h0002_A551);
    check("t1_c1_pwrite", PWRITE, 1);
    tick();
    check("t1_c2_sel", {PSELx, PENABLE}, 2'b11);
    tick();
    check("t1_c3_ack", {r0_ack, r0_err, r1_ack, PSELx, PENABLE}, 5'b10000);
    tick();
    r0_req = 0;
    check("t1_c4_idle", {r0_ack, busy}, 0);

    // 2: r1 read
    r1_req = 1; r1_write = 0; r1_addr = 32'h8000_0004; PRDATA = 32'h1234_5678;
    tick(); tick(); tick();
    check("t2_ack", {r1_ack, r1_err, r0_ack}, 3'b100);
    check("t2_rdata", r1_rdata, 32'h1234_5678);
    check("t2_grant_id", grant_id, 1);
    tick();
    r1_req = 0;

    // 3: continuous contention alternates r0, r1, r0, r1
    r0_req = 1; r0_write = 1; r0_addr = 32'h8000_0008; r0_wdata = 32'h0000_00AA;
    r1_req = 1; r1_write = 0; r1_addr = 32'h8000_000C; PRDATA = 32'hCAFE_0001;
    n_ack = 0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      check("t3_not_both", r0_ack & r1_ack, 0);
      if (r0_ack | r1_ack) begin
        check("t3_ack_cycle", c, 3 + 4 * n_ack);
        check("t3_ack_id", r1_ack, n_ack % 2);
        n_ack++;
      end
    end
    r0_req = 0; r1_req = 0;
    check("t3_ack_count", n_ack, 4);
    check("t3_r1_rdata", r1_rdata, 32'hCAFE_0001);

    // 4: out-of-window then misaligned, no bus activity
    r0_req = 1; r0_write = 0; r0_addr = 32'h8000_0010;
    tick();
    check("t4_oow_ack", {r0_ack, r0_err, PSELx}, 3'b110);
    tick();
    check("t4_gap_sel", PSELx, 0);
    r0_addr = 32'h8000_0002;
    tick();
    check("t4_mis_ack", {r0_ack, r0_err, PSELx}, 3'b110);
    check("t4_paddr_held", PADDR, 32'h8000_000C);
    check("t4_rdata_held", r0_rdata, 32'h0000_0000);
    tick();
    r0_req = 0;

    // 5: three ACCESS cycles on the second instance
    b_req = 1; b_write = 1; b_addr = 32'h8000_0008; b_wdata = 32'h5A5A_0003;
    for (int c = 1; c <= 5; c++) begin
      tick();
      check("t5_penable", b_penable, (c >= 2 && c <= 4) ? 1 : 0);
      check("t5_psel", b_psel, (c <= 4) ? 1 : 0);
      check("t5_ack", b_r0_ack, (c == 5) ? 1 : 0);
    end
    tick();
    b_req = 0;
    tick();
    check("t5_paddr_held", b_paddr, 32'h8000_0008);
    check("t5_pwdata_held", b_pwdata, 32'h5A5A_0003);

    // 6: reset during ACCESS, then both pending -> r0 first
    r0_req = 1; r0_write = 1; r0_addr = 32'h8000_0004; r0_wdata = 32'h0000_0066;
    tick(); tick();
    check("t6_in_access", {PSELx, PENABLE}, 2'b11);
    r1_req = 1; r1_write = 0; r1_addr = 32'h8000_0008; PRDATA = 32'h7777_0006;
    #2 PRESETn = 1'b0;
    #1;
    check("t6_async_clear", {PSELx, PENABLE, busy}, 0);
    tick();
    check("t6_no_ack", {r0_ack, r1_ack}, 0);
    #3 PRESETn = 1'b1;
    tick();
    check("t6_first_grant", {grant_id, PSELx}, 2'b01);
    tick(); tick();
    check("t6_r0_ack", {r0_ack, r1_ack}, 2'b10);
    tick();
    r0_req = 0;
    tick(); tick(); tick();
    check("t6_r1_ack", {r0_ack, r1_ack}, 2'b01);
    check("t6_r1_rdata", r1_rdata, 32'h7777_0006);
    tick();
    r1_req = 0;

    // Randomized phase against the transaction model
    m_rdata[0] = 32'd0;
    m_rdata[1] = 32'h7777_0006;
    m_paddr    = 32'h8000_0008;
    m_pwdata   = 32'd0;
    m_last     = 1;
    pend[0] = 0; pend[1] = 0;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i] && $urandom_range(0, 2) != 0) new_cmd(i);
      if (!pend[0] && !pend[1]) new_cmd(int'($urandom_range(0, 1)));
      prd = $urandom;
      PRDATA = prd;
      win = (pend[0] && pend[1]) ? (m_last == 1 ? 0 : 1) : (pend[1] ? 1 : 0);
      lg  = legal(ca[win]);
      exp_lat = lg ? 3 : 1;
      m_last = win;
      if (lg) begin
        m_paddr  = ca[win];
        m_pwdata = cd[win];
        if (!cw[win]) m_rdata[win] = prd;
      end
      k = 0; got = 0; sel_cnt = 0; en_cnt = 0;
      while (!got && k < 20) begin
        tick();
        k++;
        if (PSELx) sel_cnt++;
        if (PENABLE) en_cnt++;
        if (r0_ack || r1_ack) got = 1;
      end
      check("rnd_got_ack", got, 1);
      check("rnd_latency", k, exp_lat);
      check("rnd_ack_id", {r1_ack, r0_ack}, win == 1 ? 2'b10 : 2'b01);
      check("rnd_err", win == 1 ? r1_err : r0_err, lg ? 0 : 1);
      check("rnd_grant_id", grant_id, win);
      check("rnd_sel_cycles", sel_cnt, lg ? 2 : 0);
      check("rnd_en_cycles", en_cnt, lg ? 1 : 0);
      check("rnd_paddr", PADDR, m_paddr);
      check("rnd_pwdata", PWDATA, m_pwdata);
      check("rnd_r0_rdata", r0_rdata, m_rdata[0]);
      check("rnd_r1_rdata", r1_rdata, m_rdata[1]);
      pend[win] = 0;
      tick();
      check("rnd_ack_cleared", {r0_ack, r1_ack}, 0);
      if (win == 0) r0_req = 0; else r1_req = 0;
    end
    r0_req = 0; r1_req = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_i2c_req_arbiter.md
Name: apb_i2c_req_arbiter

Overview:
- APB master-side arbiter and sequencer in front of the APB-to-I2C controller (mod_top register window at 32'h8000_0000).
- Two internal requesters issue single register read/write commands. The block grants the APB port round-robin, checks the address window, and sequences SETUP/ACCESS phases with PSELx/PENABLE.
- The controller has no PREADY, so ACCESS length is a fixed parameter.
- Each requester gets a one-cycle ack carrying read data or an error flag.

Parameters:
- ADDR_BASE, 32'h8000_0000, base address of the I2C controller register window.
- ADDR_MASK, 32'hFFFF_FFF0, window mask; in-window means (addr & ADDR_MASK) == ADDR_BASE.
- ACCESS_CYCLES, 1, number of PCLK cycles PENABLE is held high; legal range 1..15.

Ports:
- PCLK  in  1  APB clock; all logic on rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- r0_req  in  1  requester 0 command request; held with fields stable until r0_ack.
- r0_write  in  1  1 = write, 0 = read.
- r0_addr  in  32  byte address.
- r0_wdata  in  32  write data.
- r0_ack  out  1  one-cycle completion pulse.
- r0_err  out  1  valid with r0_ack; 1 = rejected address.
- r0_rdata  out  32  read data, valid with r0_ack.
- r1_req, r1_write, r1_addr, r1_wdata, r1_ack, r1_err, r1_rdata: same as r0_*, for requester 1.
- PADDR  out  32  APB address.
- PSELx  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PWDATA  out  32  APB write data.
- PRDATA  in  32  APB read data from controller.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  1  requester currently/last granted.

Behaviour:
- Reset values:
  - All outputs 0: PADDR, PWDATA, PSELx, PENABLE, PWRITE, acks, errs, rdata, busy, grant_id.
  - State IDLE; last_grant = 1, so r0 wins first.
- All outputs are registered. The state register is 2-bit: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - If no req, stay.
  - If one req, grant it. If both, grant the requester other than last_grant.
  - On grant: latch addr/wdata/write, set grant_id and last_grant.
  - Address legal (in window and addr[1:0]==0) -> SETUP. Illegal -> DONE with err set; no APB activity.
- SETUP (1 cycle): PSELx=1, PENABLE=0, PADDR/PWRITE/PWDATA driven from latched values -> ACCESS.
- ACCESS:
  - PSELx=1, PENABLE=1 for exactly ACCESS_CYCLES cycles (4-bit down-counter).
  - On the edge ending the last ACCESS cycle, capture PRDATA into the granted requester's rdata (reads only; writes leave rdata unchanged) -> DONE.
- DONE (1 cycle): PSELx=0, PENABLE=0, granted ack=1, err as latched -> IDLE.
- Latency, counted from the IDLE cycle where req is sampled:
  - Legal command: ack in cycle ACCESS_CYCLES+2.
  - Illegal command: ack in cycle 1.
- Back-to-back operation:
  - Requester deasserts req (or presents a new command) in the cycle after ack; IDLE samples the new value, so there is no dead cycle.
  - A req held high across ack is treated as a new command.
- PADDR, PWDATA, PWRITE hold their last values after a transfer and are not zeroed.
- Fields changing while req is held before grant are allowed; values are sampled only at grant.
- Non-granted req is held pending with no timeout; fairness is strict alternation under continuous contention.
- Reset asserted mid-transfer:
  - Immediate (asynchronous) PSELx/PENABLE low, no ack issued, state IDLE, last_grant=1.
  - Requesters must reissue.
- No combinational path from req to APB outputs.

Decomposition:
- macros.vh (shared header): I2C window base, register offsets, state encodings (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, DONE=2'd3).
- One sub-module: rr_arb2 (two-input round-robin grant with last_grant register, one-hot grant out). FSM and APB drive stay in the top.

Test Plan:
1. r0 write, addr 32'h8000_0000, wdata 32'h0002_A551, ACCESS_CYCLES=1, req at cycle 0 -> PSELx=1 at cycle 1, PENABLE=1 at cycle 2, PWRITE=1, PWDATA=32'h0002_A551, r0_ack=1 with r0_err=0 at cycle 3, PSELx=0 at cycle 3.
2. r1 read, addr 32'h8000_0004, PRDATA=32'h1234_5678 during ACCESS -> r1_ack at cycle 3, r1_rdata=32'h1234_5678, r1_err=0, grant_id=1.
3. r0 and r1 both request from reset, held continuously -> order r0, r1, r0, r1. ack pulses 4 cycles apart (1 IDLE + 3 busy) with ACCESS_CYCLES=1; never both acks in the same cycle.
4. r0 addr 32'h8000_0010 (out of window) and addr 32'h8000_0002 (misaligned) -> r0_ack with r0_err=1 one cycle after sample; PSELx stays 0 throughout.
5. ACCESS_CYCLES=3, r0 write -> PENABLE high at cycles 2..4, ack at cycle 5; PADDR/PWDATA unchanged afterwards.
6. PRESETn pulled low during ACCESS -> PSELx/PENABLE 0 before the next PCLK edge, no ack. After release, pending r1 and r0 reqs -> r0 granted first.
